serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial, LSB-first WIDTH-bit subtractor computing a - b.
//   Inverse companion of the combinational adder datapath: consumes operands, returns difference + borrow.
//   Sits behind the tt_um top-level pins; operands from ui_in, results to uo_out.
//   Start/busy/done handshake; one bit resolved per clock.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>=2)
// PORTS
//   clk     in   1      single clock, rising edge
//   rst_n   in   1      asynchronous active-low reset
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  minuend, captured on accepted start
//   b       in   WIDTH  subtrahend, captured on accepted start
//   diff    out  WIDTH  result a - b mod 2^WIDTH (registered)
//   borrow  out  1      1 when a < b unsigned (registered)
//   busy    out  1      1 while operation in progress
//   done    out  1      one-cycle pulse: diff/borrow just updated
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; diff=0, borrow=0, busy=0, done=0; internal regs 0.
//   FSM: IDLE -> SHIFT on start=1; SHIFT -> SHIFT while cnt<WIDTH-1; SHIFT -> DONE at cnt==WIDTH-1;
//        DONE -> IDLE unconditionally (one cycle).
//   Accept (IDLE, start=1): a_sr<=a, b_sr<=b, bin<=0, cnt<=0, busy<=1 next cycle.
//   SHIFT cycle: d=a_sr[0]^b_sr[0]^bin; bout=(~a_sr[0]&b_sr[0])|(~(a_sr[0]^b_sr[0])&bin);
//     d shifted into MSB of d_sr; a_sr,b_sr shift right; bin<=bout; cnt++.
//   DONE: diff<=d_sr, borrow<=bin, done=1, busy=0. Outputs hold until next DONE.
//   Latency: start sampled at edge N -> busy high edges N+1..N+WIDTH -> done high after edge N+WIDTH+1.
//   Throughput: new start accepted the cycle after done (IDLE); back-to-back gap of 1 cycle.
//   start while busy or in DONE: ignored, no effect on in-flight operation, not queued.
//   a, b changing after acceptance: no effect.
//   a==b: diff=0, borrow=0. a=0,b=2^WIDTH-1: diff=1, borrow=1 (wrap-around mod 2^WIDTH).
//   rst_n low mid-operation: immediate abort, all outputs to reset values; no done pulse.
//   cnt width = $clog2(WIDTH); no overflow since cnt cleared on accept.
// CONFIGURATION
//   SUB_SATURATE_EN defined: on DONE with final borrow=1, diff<=0 (clamp), borrow still reported 1.
//   SUB_SATURATE_EN undefined: diff is modular two's-complement result; no clamping.
//   Timing/handshake identical in both builds.
// STRUCTURE
//   Package serial_sub_pkg: state typedef enum {IDLE, SHIFT, DONE}; default WIDTH constant.
//   Sub-module full_subtractor_bit: combinational 1-bit (a, b, bin) -> (d, bout); single instance.
//   Top: FSM, shift registers a_sr/b_sr/d_sr, borrow flop, counter, output registers.
// TESTING
//   a=9,b=3,start 1 cycle -> busy 4 cycles, done pulse 5 cycles after start edge; diff=6, borrow=0.
//   a=3,b=9 -> diff=4'hA, borrow=1 (SUB_SATURATE_EN: diff=0, borrow=1).
//   a=0,b=15 -> diff=1, borrow=1; a=7,b=7 -> diff=0, borrow=0.
//   Start at a=5,b=1, re-pulse start with a=2,b=8 while busy -> single done, diff=4, borrow=0.
//   rst_n low 2 cycles into op (a=12,b=4) -> outputs 0 immediately, no done; next op a=12,b=4 -> diff=8.
//   Back-to-back: start held high continuously -> ops complete every WIDTH+2 cycles, each correct.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Optional build macro SUB_SATURATE_EN is consumed by serial_subtractor.
package serial_sub_pkg;

  localparam int unsigned DefaultWidth = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Counter width; kept at least one bit so WIDTH==2 still yields a legal vector.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor_bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  logic w_ab_xor;

  assign w_ab_xor = i_a ^ i_b;
  assign o_d      = w_ab_xor ^ i_bin;
  assign o_bout   = (~i_a & i_b) | (~w_ab_xor & i_bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor (a - b) with start/busy/done handshake.
// Define SUB_SATURATE_EN to clamp diff to 0 whenever the final borrow is set.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_a_sr, w_a_sr_d;
  logic [WIDTH-1:0] r_b_sr, w_b_sr_d;
  logic [WIDTH-1:0] r_d_sr, w_d_sr_d;
  logic             r_bin, w_bin_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_diff, w_diff_d;
  logic             r_borrow, w_borrow_d;
  logic             r_busy, w_busy_d;
  logic             r_done, w_done_d;

  logic w_d;
  logic w_bout;

  full_subtractor_bit u_fsb (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_bin  (r_bin),
    .o_d    (w_d),
    .o_bout (w_bout)
  );

  always_comb begin
    w_state_d  = r_state;
    w_a_sr_d   = r_a_sr;
    w_b_sr_d   = r_b_sr;
    w_d_sr_d   = r_d_sr;
    w_bin_d    = r_bin;
    w_cnt_d    = r_cnt;
    w_diff_d   = r_diff;
    w_borrow_d = r_borrow;
    w_done_d   = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StShift;
          w_a_sr_d  = a;
          w_b_sr_d  = b;
          w_d_sr_d  = '0;
          w_bin_d   = 1'b0;
          w_cnt_d   = '0;
        end
      end
      StShift: begin
        // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        w_a_sr_d = r_a_sr >> 1;
        w_b_sr_d = r_b_sr >> 1;
        w_d_sr_d = {w_d, r_d_sr[WIDTH-1:1]};
        w_bin_d  = w_bout;
        w_cnt_d  = r_cnt + 1'b1;
        if (r_cnt == LastCnt) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_state_d  = StIdle;
        w_borrow_d = r_bin;
        w_done_d   = 1'b1;
`ifdef SUB_SATURATE_EN
        w_diff_d   = r_bin ? '0 : r_d_sr;
`else
        w_diff_d   = r_d_sr;
`endif
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    w_busy_d = (w_state_d == StShift);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_d_sr   <= '0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_a_sr   <= w_a_sr_d;
      r_b_sr   <= w_b_sr_d;
      r_d_sr   <= w_d_sr_d;
      r_bin    <= w_bin_d;
      r_cnt    <= w_cnt_d;
      r_diff   <= w_diff_d;
      r_borrow <= w_borrow_d;
      r_busy   <= w_busy_d;
      r_done   <= w_done_d;
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=4).
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] diff;
  logic       borrow;
  logic       busy;
  logic       done;

  int errors;
  int checks;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .diff   (diff),
    .borrow (borrow),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

  // Called at a negedge while idle. One start pulse, then observe 10 cycles.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                        output logic [3:0] od, output logic ob,
                        output int busy_n, output int done_n, output int lat);
    od = '0; ob = 1'b0; busy_n = 0; done_n = 0; lat = -1;
    a = ia; b = ib; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = ~ia;
    b = ~ib;
    for (int e = 0; e < 10; e++) begin
      if (e > 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (lat < 0) begin
          lat = e;
          od = diff;
          ob = borrow;
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++; if (diff !== 4'h0) begin errors++; $display("FAIL reset_diff: got %h want 0", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow: got %b want 0", borrow); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_basic();
    logic [3:0] d; logic bo; int bn, dn, lat;
    run_op(4'd9, 4'd3, d, bo, bn, dn, lat);
    checks++; if (bn !== 4) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 4", bn); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency: got %0d want 5", lat); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", dn); end
    checks++; if (d !== 4'd6) begin errors++; $display("FAIL basic_diff: got %h want 6", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL basic_borrow: got %b want 0", bo); end
  endtask

  task automatic test_borrow();
    logic [3:0] d; logic bo; int bn, dn, lat;
    logic [3:0] exp_d;
`ifdef SUB_SATURATE_EN
    exp_d = 4'h0;
`else
    exp_d = 4'hA;
`endif
    run_op(4'd3, 4'd9, d, bo, bn, dn, lat);
    checks++; if (d !== exp_d) begin errors++; $display("FAIL borrow_diff: got %h want %h", d, exp_d); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL borrow_flag: got %b want 1", bo); end
  endtask

  task automatic test_edges();
    logic [3:0] d; logic bo; int bn, dn, lat;
    logic [3:0] exp_d;
`ifdef SUB_SATURATE_EN
    exp_d = 4'h0;
`else
    exp_d = 4'h1;
`endif
    run_op(4'd0, 4'd15, d, bo, bn, dn, lat);
    checks++; if (d !== exp_d) begin errors++; $display("FAIL wrap_diff: got %h want %h", d, exp_d); end
    checks++; if (bo !== 1'b1) begin errors++; $display("FAIL wrap_borrow: got %b want 1", bo); end
    run_op(4'd7, 4'd7, d, bo, bn, dn, lat);
    checks++; if (d !== 4'h0) begin errors++; $display("FAIL equal_diff: got %h want 0", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL equal_borrow: got %b want 0", bo); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL equal_latency: got %0d want 5", lat); end
  endtask

  task automatic test_ignore_start();
    int dn; logic [3:0] d; logic bo;
    dn = 0; d = '0; bo = 1'b0;
    a = 4'd5; b = 4'd1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    a = 4'd2; b = 4'd8; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    for (int e = 2; e < 12; e++) begin
      if (done) begin
        dn++;
        d = diff;
        bo = borrow;
      end
      @(posedge clk); @(negedge clk);
    end
    checks++; if (dn !== 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", dn); end
    checks++; if (d !== 4'd4) begin errors++; $display("FAIL ignore_diff: got %h want 4", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL ignore_borrow: got %b want 0", bo); end
  endtask

  task automatic test_hold();
    a = 4'd1; b = 4'd1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++; if (diff !== 4'd4) begin errors++; $display("FAIL hold_diff: got %h want 4", diff); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL hold_done: got %b want 0", done); end
  endtask

  task automatic test_reset_abort();
    int dn, bn; logic [3:0] d; logic bo; int lat;
    dn = 0; bn = 0;
    a = 4'd12; b = 4'd4; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (diff !== 4'd0) begin errors++; $display("FAIL abort_diff: got %h want 0", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL abort_borrow: got %b want 0", borrow); end
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      if (done) dn++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      if (done) dn++;
      if (busy) bn++;
    end
    checks++; if (dn !== 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dn); end
    checks++; if (bn !== 0) begin errors++; $display("FAIL abort_no_busy: got %0d want 0", bn); end
    run_op(4'd12, 4'd4, d, bo, bn, dn, lat);
    checks++; if (d !== 4'd8) begin errors++; $display("FAIL abort_rerun_diff: got %h want 8", d); end
    checks++; if (bo !== 1'b0) begin errors++; $display("FAIL abort_rerun_borrow: got %b want 0", bo); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic [3:0] ed [4];
    logic       eb [4];
    int k, c, last_c;
    va[0] = 4'd9;  vb[0] = 4'd3;  ed[0] = 4'h6; eb[0] = 1'b0;
    va[1] = 4'd1;  vb[1] = 4'd2;  eb[1] = 1'b1;
    va[2] = 4'd15; vb[2] = 4'd1;  ed[2] = 4'hE; eb[2] = 1'b0;
    va[3] = 4'd8;  vb[3] = 4'd8;  ed[3] = 4'h0; eb[3] = 1'b0;
`ifdef SUB_SATURATE_EN
    ed[1] = 4'h0;
`else
    ed[1] = 4'hF;
`endif
    k = 0; c = 0; last_c = -5;
    a = va[0]; b = vb[0]; start = 1'b1;
    while (k < 4 && c < 40) begin
      @(posedge clk); @(negedge clk);
      c++;
      if (done) begin
        checks++;
        if (diff !== ed[k]) begin
          errors++; $display("FAIL b2b_diff[%0d]: got %h want %h", k, diff, ed[k]);
        end
        checks++;
        if (borrow !== eb[k]) begin
          errors++; $display("FAIL b2b_borrow[%0d]: got %b want %b", k, borrow, eb[k]);
        end
        checks++;
        if ((c - last_c) !== ((k == 0) ? 11 : 6)) begin
          errors++; $display("FAIL b2b_spacing[%0d]: got %0d want %0d", k, c - last_c,
                             (k == 0) ? 11 : 6);
        end
        last_c = c;
        k++;
        if (k < 4) begin
          a = va[k]; b = vb[k];
        end
      end
    end
    start = 1'b0;
    checks++;
    if (k !== 4) begin errors++; $display("FAIL b2b_completed: got %0d want 4", k); end
    repeat (8) begin @(posedge clk); @(negedge clk); end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_borrow();
    test_edges();
    test_ignore_start();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
